// File: rtl/sprite_bus_pkg.sv
// sprite_bus_pkg: shared state encoding, defaults and sizing helper for the sprite bus
package sprite_bus_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHANNELS = 4;
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, TURN} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/sprite_bus_driver_arb_rr_arbiter.sv
// rr_arbiter: picks the first requester at or above ptr, wrapping, as one-hot and index
module rr_arbiter
  import sprite_bus_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int IW = clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [IW-1:0]       ptr,
  output logic [CHANNELS-1:0] onehot,
  output logic [IW-1:0]       idx,
  output logic                valid
);
  // scan offsets from the far end down so the nearest requester after ptr wins
  always_comb begin
    idx = '0;
    for (int k = CHANNELS - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % CHANNELS]) idx = IW'((int'(ptr) + k) % CHANNELS);
  end
  assign valid = |req;
  assign onehot = valid ? {{(CHANNELS-1){1'b0}}, 1'b1} << idx : '0;
endmodule

// File: rtl/sprite_bus_driver_arb.sv
// sprite_bus_driver_arb: round-robin owner of the shared sprite data bus with turnaround gaps
module sprite_bus_driver_arb
  import sprite_bus_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int HOLD_CYCLES = 2,
  parameter int TURNAROUND = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [CHANNELS-1:0]       req,
  input  logic [CHANNELS-1:0]       wr,
  input  logic [CHANNELS*WIDTH-1:0] wdata,
  output logic [CHANNELS-1:0]       ack,
  output logic [WIDTH-1:0]          rdata,
  output logic [CHANNELS-1:0]       grant,
  output logic                      bus_oe,
  output logic [WIDTH-1:0]          bus_dout,
  input  logic [WIDTH-1:0]          bus_din,
  output logic                      busy
);
  localparam int IW = clog2(CHANNELS);
  localparam int MAXC = HOLD_CYCLES > TURNAROUND ? HOLD_CYCLES : TURNAROUND;
  localparam int CW = clog2(MAXC + 1);
  state_t state;
  logic [1:0] rs;
  logic [CW-1:0] cnt;
  logic [IW-1:0] ptr, widx;
  logic [CHANNELS-1:0] wone;
  logic wvalid;
  rr_arbiter #(.CHANNELS(CHANNELS), .IW(IW)) u_arb (
    .req(req),
    .ptr(ptr),
    .onehot(wone),
    .idx(widx),
    .valid(wvalid)
  );
  assign busy = state != IDLE;
  // release of reset is retimed here; arbitration waits until rs[1] is set
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) rs <= '0;
    else rs <= {rs[0], 1'b1};
  // bus ownership FSM; the owner's wr and wdata are frozen into state and bus_dout at grant
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      ptr <= '0;
      grant <= '0;
      ack <= '0;
      bus_oe <= 1'b0;
      bus_dout <= '0;
      rdata <= '0;
    end else begin
      case (state)
        IDLE:
          if (rs[1] && wvalid) begin
            grant <= wone;
            ptr <= (widx == IW'(CHANNELS - 1)) ? '0 : widx + 1'b1;
            cnt <= CW'(HOLD_CYCLES - 1);
            ack <= (HOLD_CYCLES == 1) ? wone : '0;
            if (wr[widx]) begin
              state <= DRIVE;
              bus_oe <= 1'b1;
              bus_dout <= wdata[widx*WIDTH +: WIDTH];
            end else begin
              state <= SAMPLE;
              if (HOLD_CYCLES == 1) rdata <= bus_din;
            end
          end
        DRIVE, SAMPLE:
          if (cnt == '0) begin
            grant <= '0;
            ack <= '0;
            bus_oe <= 1'b0;
            bus_dout <= '0;
            state <= (state == DRIVE && TURNAROUND > 0) ? TURN : IDLE;
            cnt <= CW'(TURNAROUND > 0 ? TURNAROUND - 1 : 0);
          end else begin
            cnt <= cnt - 1'b1;
            ack <= (cnt == CW'(1)) ? grant : '0;
            if (state == SAMPLE && cnt == CW'(1)) rdata <= bus_din;
          end
        TURN:
          if (cnt == '0) state <= IDLE;
          else cnt <= cnt - 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_sprite_bus_driver_arb.sv
// tb_sprite_bus_driver_arb: random and directed traffic on TURNAROUND=1 and TURNAROUND=0 instances
module tb_sprite_bus_driver_arb;
  localparam int H = 2;
  logic clk = 1'b0;
  logic reset_n;
  logic [3:0] req, wr;
  logic [63:0] wdata;
  logic [15:0] bus_din;
  logic [3:0] ack [2];
  logic [3:0] grant [2];
  logic [15:0] rdata [2];
  logic [15:0] dout [2];
  logic oe [2];
  logic busy [2];
  int n_tests = 0, n_fail = 0;
  int pos [2] = '{-1, -1};
  int ptrm [2] = '{0, 0};
  int win [2] = '{0, 0};
  int tn [2] = '{1, 0};
  logic isw [2] = '{1'b0, 1'b0};
  logic [15:0] dat [2] = '{16'h0, 16'h0};
  logic [15:0] rdm [2] = '{16'h0, 16'h0};

  always #5 clk = ~clk;

  sprite_bus_driver_arb #(.WIDTH(16), .CHANNELS(4), .HOLD_CYCLES(H), .TURNAROUND(1)) u0 (
    .clk(clk), .reset_n(reset_n), .req(req), .wr(wr), .wdata(wdata), .ack(ack[0]),
    .rdata(rdata[0]), .grant(grant[0]), .bus_oe(oe[0]), .bus_dout(dout[0]),
    .bus_din(bus_din), .busy(busy[0])
  );
  sprite_bus_driver_arb #(.WIDTH(16), .CHANNELS(4), .HOLD_CYCLES(H), .TURNAROUND(0)) u1 (
    .clk(clk), .reset_n(reset_n), .req(req), .wr(wr), .wdata(wdata), .ack(ack[1]),
    .rdata(rdata[1]), .grant(grant[1]), .bus_oe(oe[1]), .bus_dout(dout[1]),
    .bus_din(bus_din), .busy(busy[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // transfer-level reference: a granted transfer occupies H bus cycles, then the
  // turnaround (writes only), then one idle cycle in which the next winner is chosen
  task automatic model(input int k);
    int w;
    if (pos[k] >= 0) begin
      pos[k]++;
      if (pos[k] == H + (isw[k] ? tn[k] : 0) + 1) pos[k] = -1;
    end
    if (pos[k] < 0 && req != 4'b0) begin
      w = -1;
      for (int j = 0; j < 4; j++) if (w < 0 && req[(ptrm[k] + j) % 4]) w = (ptrm[k] + j) % 4;
      pos[k] = 0;
      win[k] = w;
      isw[k] = wr[w];
      dat[k] = wdata[w*16 +: 16];
      ptrm[k] = (w + 1) % 4;
    end
    if (pos[k] == H - 1 && !isw[k]) rdm[k] = bus_din;
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      logic xf;
      logic [3:0] eg;
      xf = pos[k] >= 0 && pos[k] < H;
      eg = xf ? 4'b0001 << win[k] : 4'b0000;
      check($sformatf("u%0d.grant", k), 32'(grant[k]), 32'(eg));
      check($sformatf("u%0d.bus_oe", k), 32'(oe[k]), 32'(xf && isw[k]));
      check($sformatf("u%0d.bus_dout", k), 32'(dout[k]), (xf && isw[k]) ? 32'(dat[k]) : 32'h0);
      check($sformatf("u%0d.ack", k), 32'(ack[k]), pos[k] == H - 1 ? 32'(eg) : 32'h0);
      check($sformatf("u%0d.rdata", k), 32'(rdata[k]), 32'(rdm[k]));
      check($sformatf("u%0d.busy", k), 32'(busy[k]),
            32'(pos[k] >= 0 && pos[k] < H + (isw[k] ? tn[k] : 0)));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++)
      if (reset_n) model(k);
      else begin
        pos[k] = -1;
        ptrm[k] = 0;
        rdm[k] = 16'h0;
      end
    #1;
    compare_all();
  endtask

  initial begin
    reset_n = 1'b0;
    req = '0;
    wr = '0;
    wdata = '0;
    bus_din = '0;
    repeat (3) tick();
    // deassertion: no grant may appear at the first edge even with everyone requesting
    reset_n = 1'b1;
    req = 4'b1111;
    @(posedge clk);
    #1;
    check("sync_first_edge_u0", 32'(grant[0]), 32'h0);
    check("sync_first_edge_u1", 32'(grant[1]), 32'h0);
    req = '0;
    repeat (3) tick();
    // single write on ch2
    req = 4'b0100;
    wr = 4'b0100;
    wdata[32 +: 16] = 16'hA5A5;
    tick();
    check("wr_grant", 32'(grant[0]), 32'h4);
    check("wr_dout1", 32'(dout[0]), 32'hA5A5);
    tick();
    check("wr_ack", 32'(ack[0]), 32'h4);
    check("wr_oe2", 32'(oe[0]), 32'h1);
    req = '0;
    tick();
    check("wr_turn_oe", 32'(oe[0]), 32'h0);
    repeat (3) tick();
    // single read on ch1
    bus_din = 16'h1234;
    req = 4'b0010;
    wr = 4'b0000;
    tick();
    check("rd_oe", 32'(oe[0]), 32'h0);
    tick();
    check("rd_data", 32'(rdata[0]), 32'h1234);
    check("rd_ack", 32'(ack[0]), 32'h2);
    req = '0;
    repeat (3) tick();
    // round-robin with every channel writing
    req = 4'b1111;
    wr = 4'b1111;
    wdata = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
    repeat (30) tick();
    req = '0;
    repeat (6) tick();
    // ch3 withdraws and changes its data right after grant
    req = 4'b1000;
    wr = 4'b1000;
    wdata[48 +: 16] = 16'hBEEF;
    tick();
    req = '0;
    wdata[48 +: 16] = 16'h0000;
    tick();
    check("wd_dout", 32'(dout[0]), 32'hBEEF);
    check("wd_ack", 32'(ack[0]), 32'h8);
    repeat (4) tick();
    // reset in the middle of a ch2 write
    req = 4'b0100;
    wr = 4'b0100;
    tick();
    #2 reset_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("ar_oe_u%0d", k), 32'(oe[k]), 32'h0);
      check($sformatf("ar_grant_u%0d", k), 32'(grant[k]), 32'h0);
      check($sformatf("ar_ack_u%0d", k), 32'(ack[k]), 32'h0);
    end
    req = '0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    req = 4'b1111;
    tick();
    check("ar_ptr_restart", 32'(grant[0]), 32'h1);
    req = '0;
    repeat (6) tick();
    // random traffic
    for (int c = 0; c < 1500; c++) begin
      req = 4'($urandom_range(0, 15));
      wr = 4'($urandom_range(0, 15));
      wdata = {$urandom, $urandom};
      if (pos[0] < 0 && pos[1] < 0) bus_din = 16'($urandom);
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
